mem_scan_reader: RTL and testbench



---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_scan_reader_if.sv | 26 ++
 rtl/hex7seg.sv | 13 +
 rtl/mem_scan_reader.sv | 119 +++++++++++
 tb/tb_mem_scan_reader.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared parameters, FSM state type and 7-segment helper
// for the switch-programmed memory and its read-out path.
package mem_pkg;

    localparam int MEM_ADDR_W = 2;
    localparam int MEM_DATA_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } scan_state_t;

    // Active-high segments, bit 7 is the decimal point (kept dark).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] s;
        case (hex)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_scan_reader_if.sv
// Read port of the switch-programmed memory: the scanner is
// the master (strobe + address), the memory returns data.
interface mem_scan_reader_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/hex7seg.sv
// Combinational 7-segment decoder for one nibble,
// shared with the memory display path via mem_pkg.
module hex7seg
    import mem_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    // Pure table lookup of the displayed nibble.
    always_comb seg = hex_to_seg(hex);

endmodule

// File: rtl/mem_scan_reader.sv
// Walks every memory address, shows each word on the display
// for HOLD_CYCLES cycles and reports the per-pass sum.
module mem_scan_reader
    import mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                     clk_2,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     loop,
    input  logic                     pause,
    mem_scan_reader_if.master        bus,
    output logic [ADDR_W-1:0]        cur_addr,
    output logic [DATA_W-1:0]        cur_data,
    output logic [7:0]               seg,
    output logic [ADDR_W+DATA_W-1:0] sum,
    output logic                     pass_done,
    output logic                     busy
);

    localparam int SUM_W = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    scan_state_t       state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  hold_cnt;
    logic [SUM_W-1:0]  acc;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;

    // Scan sequencer; every output it drives is a register.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            hold_cnt  <= '0;
            acc       <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            cur_addr  <= '0;
            cur_data  <= '0;
            sum       <= '0;
            pass_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rd_en_q   <= 1'b0;
            pass_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    addr <= '0;
                    acc  <= '0;
                    if (start) begin
                        state     <= S_REQ;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_REQ: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    cur_data <= bus.rd_data;
                    cur_addr <= addr;
                    acc      <= acc + SUM_W'(bus.rd_data);
                    hold_cnt <= HOLD_LOAD;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (!pause) begin
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end else if (addr != LAST_ADDR) begin
                            addr      <= addr + 1'b1;
                            rd_addr_q <= addr + 1'b1;
                            rd_en_q   <= 1'b1;
                            state     <= S_REQ;
                        end else begin
                            // sum and pass_done land together in DONE
                            sum       <= acc;
                            pass_done <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    acc  <= '0;
                    addr <= '0;
                    if (loop) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        state     <= S_REQ;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    hex7seg u_seg (
        .hex (cur_data[3:0]),
        .seg (seg)
    );

endmodule

// File: tb/tb_mem_scan_reader.sv
// Bench for mem_scan_reader: table vectors, random passes against
// a cycle-count model, and hand-written reset/loop/restart cases.
module tb_mem_scan_reader;
    import mem_pkg::*;

    logic clk_2 = 1'b0;
    logic reset, start, loop, pause;
    logic start2;

    logic [1:0] cur_addr, cur_addr2;
    logic [3:0] cur_data, cur_data2;
    logic [7:0] seg, seg2;
    logic [5:0] sum, sum2;
    logic       pass_done, pass_done2, busy, busy2;

    mem_scan_reader_if #(.ADDR_W(2), .DATA_W(4)) bus1 ();
    mem_scan_reader_if #(.ADDR_W(2), .DATA_W(4)) bus2 ();

    mem_scan_reader #(.ADDR_W(2), .DATA_W(4), .HOLD_CYCLES(4)) dut (
        .clk_2(clk_2), .reset(reset), .start(start), .loop(loop),
        .pause(pause), .bus(bus1), .cur_addr(cur_addr),
        .cur_data(cur_data), .seg(seg), .sum(sum),
        .pass_done(pass_done), .busy(busy)
    );

    mem_scan_reader #(.ADDR_W(2), .DATA_W(4), .HOLD_CYCLES(1)) dut2 (
        .clk_2(clk_2), .reset(reset), .start(start2), .loop(1'b0),
        .pause(1'b0), .bus(bus2), .cur_addr(cur_addr2),
        .cur_data(cur_data2), .seg(seg2), .sum(sum2),
        .pass_done(pass_done2), .busy(busy2)
    );

    always #5 clk_2 = ~clk_2;

    logic [3:0] mem1 [4];
    logic [3:0] mem2 [4];

    // Memory model: registered read, data valid the cycle after rd_en.
    always @(posedge clk_2) begin
        if (bus1.rd_en) bus1.rd_data <= mem1[bus1.rd_addr];
        if (bus2.rd_en) bus2.rd_data <= mem2[bus2.rd_addr];
    end

    logic [7:0] seg_tab [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;

    int         rd_cyc [$];
    logic [1:0] rd_adr [$];
    int         done_cyc [$];
    logic [5:0] done_sum [$];
    logic [1:0] cap_addr [$];
    logic [3:0] cap_data [$];
    logic [7:0] cap_seg [$];

    // Free-running edge counter for relative cycle numbers.
    always @(posedge clk_2) cyc <= cyc + 1;

    // Log read strobes, completions and the display after each capture.
    always @(negedge clk_2) begin
        int mrel;
        mrel = cyc - base + 1;
        if (rd_cyc.size() > 0 && rd_cyc[$] == mrel - 2) begin
            cap_addr.push_back(cur_addr);
            cap_data.push_back(cur_data);
            cap_seg.push_back(seg);
        end
        if (bus1.rd_en) begin
            rd_cyc.push_back(mrel);
            rd_adr.push_back(bus1.rd_addr);
        end
        if (pass_done) begin
            done_cyc.push_back(mrel);
            done_sum.push_back(sum);
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_cyc.delete();
        rd_adr.delete();
        done_cyc.delete();
        done_sum.delete();
        cap_addr.delete();
        cap_data.delete();
        cap_seg.delete();
    endtask

    // One pass from a start pulse; pause window, optional restart pulse.
    task automatic run(input bit lp, input int pstart, input int plen,
                       input int rs, input int ndone, input int limit);
        @(negedge clk_2);
        start = 1'b1;
        loop  = lp;
        @(posedge clk_2);
        #1;
        base = cyc;
        clear_logs();
        start = 1'b0;
        for (int r = 1; r <= limit; r++) begin
            pause = (r >= pstart) && (r < pstart + plen);
            start = (r == rs);
            if (lp && done_cyc.size() > 0 && r > done_cyc[0] + 1)
                loop = 1'b0;
            @(negedge clk_2);
            if (ndone > 0 && done_cyc.size() >= ndone) break;
            @(posedge clk_2);
            #1;
        end
        pause = 1'b0;
        start = 1'b0;
        loop  = 1'b0;
    endtask

    // Compare a logged pass with what the memory contents predict.
    task automatic check_pass(input string tag, input logic [3:0][3:0] m,
                              input int pk, input int plen,
                              input int exp_done, input logic [5:0] exp_sum,
                              input logic [3:0][7:0] exp_seg);
        int exp_rd;
        chk({tag, "_rdcnt"}, rd_cyc.size(), 4);
        chk({tag, "_donecnt"}, done_cyc.size(), 1);
        for (int j = 0; j < 4 && j < rd_cyc.size(); j++) begin
            exp_rd = 1 + 6 * j + ((j > pk) ? plen : 0);
            chk($sformatf("%s_rdaddr%0d", tag, j), rd_adr[j], j);
            chk($sformatf("%s_rdcyc%0d", tag, j), rd_cyc[j], exp_rd);
        end
        for (int j = 0; j < 4 && j < cap_seg.size(); j++) begin
            chk($sformatf("%s_caddr%0d", tag, j), cap_addr[j], j);
            chk($sformatf("%s_cdata%0d", tag, j), cap_data[j], m[j]);
            chk($sformatf("%s_seg%0d", tag, j), cap_seg[j], exp_seg[j]);
        end
        if (done_cyc.size() > 0) begin
            chk({tag, "_donecyc"}, done_cyc[0], exp_done);
            chk({tag, "_sum"}, done_sum[0], exp_sum);
        end
        @(posedge clk_2);
        @(negedge clk_2);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    typedef struct packed {
        logic [3:0][3:0] m;
        int              pk;
        int              ps;
        int              pl;
        int              done;
        logic [5:0]      sum;
        logic [3:0][7:0] sg;
    } vec_t;

    function automatic vec_t mk(input logic [3:0][3:0] m, input int pk,
                                input int ps, input int pl, input int d,
                                input logic [5:0] s,
                                input logic [3:0][7:0] sg);
        vec_t v;
        v.m = m; v.pk = pk; v.ps = ps; v.pl = pl;
        v.done = d; v.sum = s; v.sg = sg;
        return v;
    endfunction

    vec_t tab [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [3:0][3:0] rm;
        logic [3:0][7:0] rsg;
        int rsum, rpk, rpl, rps;
        int n, d2;
        logic [5:0] s2;

        tab[0] = mk({4'hF, 4'h0, 4'hA, 4'h3}, 0, 0, 0, 25, 6'h1C,
                    {8'h71, 8'h3F, 8'h77, 8'h4F});
        tab[1] = mk({4'hF, 4'h0, 4'hA, 4'h3}, 1, 9, 10, 35, 6'h1C,
                    {8'h71, 8'h3F, 8'h77, 8'h4F});
        tab[2] = mk({4'h8, 4'h4, 4'h2, 4'h1}, 3, 22, 3, 28, 6'h0F,
                    {8'h7F, 8'h66, 8'h5B, 8'h06});
        tab[3] = mk({4'h9, 4'h7, 4'h6, 4'h5}, 0, 4, 1, 26, 6'h1B,
                    {8'h6F, 8'h07, 8'h7D, 8'h6D});
        tab[4] = mk({4'hE, 4'hD, 4'hC, 4'hB}, 0, 0, 0, 25, 6'h32,
                    {8'h79, 8'h5E, 8'h39, 8'h7C});

        reset = 1'b1; start = 1'b0; loop = 1'b0; pause = 1'b0;
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) mem2[k] = 4'hF;
        repeat (2) @(posedge clk_2);
        @(negedge clk_2);
        chk("rst_rd_en", bus1.rd_en, 0);
        chk("rst_rd_addr", bus1.rd_addr, 0);
        chk("rst_cur_addr", cur_addr, 0);
        chk("rst_cur_data", cur_data, 0);
        chk("rst_seg", seg, 8'h3F);
        chk("rst_sum", sum, 0);
        chk("rst_pass_done", pass_done, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) mem1[k] = tab[i].m[k];
            run(1'b0, tab[i].ps, tab[i].pl, 0, 1, 80);
            check_pass($sformatf("tab%0d", i), tab[i].m, tab[i].pk,
                       tab[i].pl, tab[i].done, tab[i].sum, tab[i].sg);
        end

        for (int t = 0; t < 8; t++) begin
            rsum = 0;
            for (int k = 0; k < 4; k++) begin
                rm[k] = 4'($urandom_range(0, 15));
                rsum += int'(rm[k]);
                rsg[k] = seg_tab[rm[k]];
                mem1[k] = rm[k];
            end
            rpk = $urandom_range(0, 3);
            rpl = $urandom_range(0, 12);
            rps = 3 + 6 * rpk + $urandom_range(0, 3);
            run(1'b0, rps, rpl, 0, 1, 100);
            check_pass($sformatf("rnd%0d", t), rm, rpk, rpl,
                       25 + rpl, 6'(rsum), rsg);
        end

        mem1[0] = 4'h3; mem1[1] = 4'hA; mem1[2] = 4'h0; mem1[3] = 4'hF;
        run(1'b1, 0, 0, 0, 2, 80);
        chk("loop_donecnt", done_cyc.size(), 2);
        chk("loop_rdcnt", rd_cyc.size(), 8);
        if (done_cyc.size() == 2 && rd_cyc.size() == 8) begin
            chk("loop_done0", done_cyc[0], 25);
            chk("loop_rd4cyc", rd_cyc[4], 26);
            chk("loop_rd4addr", rd_adr[4], 0);
            chk("loop_done1", done_cyc[1], 50);
            chk("loop_sum1", done_sum[1], 6'h1C);
        end
        @(posedge clk_2);
        @(negedge clk_2);
        chk("loop_idle_busy", busy, 0);

        run(1'b0, 0, 0, 0, 0, 16);
        chk("mid_cur_addr", cur_addr, 2);
        reset = 1'b1;
        @(posedge clk_2);
        #1;
        reset = 1'b0;
        @(negedge clk_2);
        chk("mrst_busy", busy, 0);
        chk("mrst_seg", seg, 8'h3F);
        chk("mrst_cur_addr", cur_addr, 0);
        chk("mrst_cur_data", cur_data, 0);
        chk("mrst_sum", sum, 0);
        chk("mrst_rd_en", bus1.rd_en, 0);
        run(1'b0, 0, 0, 0, 1, 80);
        check_pass("after_rst", tab[0].m, 0, 0, 25, 6'h1C, tab[0].sg);

        run(1'b0, 0, 0, 10, 1, 80);
        check_pass("restart", tab[0].m, 0, 0, 25, 6'h1C, tab[0].sg);

        @(negedge clk_2);
        start2 = 1'b1;
        @(posedge clk_2);
        #1;
        start2 = 1'b0;
        n = 0;
        d2 = 0;
        s2 = '0;
        for (int r = 1; r <= 30; r++) begin
            @(negedge clk_2);
            if (bus2.rd_en) begin
                chk($sformatf("h1_rdcyc%0d", n), r, 1 + 3 * n);
                chk($sformatf("h1_rdaddr%0d", n), bus2.rd_addr, n);
                n++;
            end
            if (pass_done2) begin
                d2 = r;
                s2 = sum2;
                break;
            end
            @(posedge clk_2);
        end
        chk("h1_rdcnt", n, 4);
        chk("h1_donecyc", d2, 13);
        chk("h1_sum", s2, 6'h3C);
        chk("h1_cur_data", cur_data2, 4'hF);
        chk("h1_seg", seg2, 8'h71);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
